// File: rtl/dac_serial_tx.sv
// Serializer for a 12-bit SPI-style DAC: one parallel sample per start pulse becomes a
// 16-bit Sync/Sclk/Data_DAC frame, followed by a Sync-high gap before done.
module dac_serial_tx #(
    parameter int         N_ADC   = 12,
    parameter int         CLK_DIV = 4,
    parameter logic [1:0] PD_MODE = 2'b00
) (
    input  logic             clock_In,
    input  logic             Reset,
    input  logic [N_ADC-1:0] data_In,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             Sync,
    output logic             Sclk,
    output logic             Data_DAC
);

    localparam int FW  = N_ADC + 4;
    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = $clog2(FW + 1);
    localparam logic [HCW-1:0] HC_MAX = HCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BC_END = BCW'(FW);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t         state, state_next;
    logic [HCW-1:0] hc, hc_next;
    logic [BCW-1:0] bit_cnt, bit_cnt_next;
    logic [FW-1:0]  shreg, shreg_next;
    logic [FW-1:0]  frame;
    logic           sync_next, sclk_next, data_next, busy_next, done_next;
    logic           hc_wrap, frame_end;

    assign frame     = {2'b00, PD_MODE, data_In};
    assign hc_wrap   = (hc == HC_MAX);
    // The rise that follows the last falling edge closes the frame instead of shifting
    assign frame_end = hc_wrap && !Sclk && (bit_cnt == BC_END);

    always_ff @(posedge clock_In or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            hc       <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            Sync     <= 1'b1;
            Sclk     <= 1'b1;
            Data_DAC <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            hc       <= hc_next;
            bit_cnt  <= bit_cnt_next;
            shreg    <= shreg_next;
            Sync     <= sync_next;
            Sclk     <= sclk_next;
            Data_DAC <= data_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = SHIFT;
            SHIFT:   if (frame_end) state_next = GAP;
            GAP:     if (hc_wrap)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Next values of every registered output, so nothing combinational reaches a port
    always_comb begin
        hc_next      = hc;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        sync_next    = Sync;
        sclk_next    = Sclk;
        data_next    = Data_DAC;
        busy_next    = busy;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                busy_next = start;
                if (start) begin
                    shreg_next   = frame;
                    hc_next      = '0;
                    bit_cnt_next = '0;
                    sync_next    = 1'b0;
                    sclk_next    = 1'b1;
                    data_next    = frame[FW-1];
                end
            end
            SHIFT: begin
                hc_next = hc_wrap ? '0 : hc + 1'b1;
                if (hc_wrap) begin
                    if (Sclk) begin
                        sclk_next    = 1'b0;
                        bit_cnt_next = bit_cnt + 1'b1;
                    end else if (bit_cnt == BC_END) begin
                        sclk_next = 1'b1;
                        sync_next = 1'b1;
                        data_next = 1'b0;
                    end else begin
                        sclk_next  = 1'b1;
                        shreg_next = shreg << 1;
                        data_next  = shreg[FW-2];
                    end
                end
            end
            GAP: begin
                hc_next = hc_wrap ? '0 : hc + 1'b1;
                if (hc_wrap) begin
                    done_next = 1'b1;
                    busy_next = 1'b0;
                end
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Scoreboard bench for dac_serial_tx: two instances (CLK_DIV=4/PD=00 and CLK_DIV=2/PD=11)
// share clock and reset; a negedge monitor rebuilds each frame and checks it against a queue.
module tb_dac_serial_tx;

    localparam int C0 = 4;
    localparam int C1 = 2;

    logic        clock_In = 1'b0;
    logic        Reset;
    logic [11:0] data0, data1;
    logic        start0, start1;
    logic        busy0, done0, sync0, sclk0, dac0;
    logic        busy1, done1, sync1, sclk1, dac1;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    bit          active[2];
    int          t_c[2];
    int          falls[2];
    logic [15:0] word[2];
    logic        p_sync[2], p_sclk[2], p_data[2];
    int          since_chg[2], since_fall[2];
    int          high_cnt[2], gap_len[2];
    bit          busy_bad[2], stab_bad[2], sclk_bad[2];

    always #5 clock_In = ~clock_In;

    dac_serial_tx #(.N_ADC(12), .CLK_DIV(C0), .PD_MODE(2'b00)) dut0 (
        .clock_In(clock_In), .Reset(Reset), .data_In(data0), .start(start0),
        .busy(busy0), .done(done0), .Sync(sync0), .Sclk(sclk0), .Data_DAC(dac0)
    );

    dac_serial_tx #(.N_ADC(12), .CLK_DIV(C1), .PD_MODE(2'b11)) dut1 (
        .clock_In(clock_In), .Reset(Reset), .data_In(data1), .start(start1),
        .busy(busy1), .done(done1), .Sync(sync1), .Sclk(sclk1), .Data_DAC(dac1)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic monitorStep(input int id, input int cdiv, input logic rst,
                               input logic s, input logic k, input logic d,
                               input logic b, input logic dn);
        logic [15:0] exp;
        bit fell, chg;
        if (rst) begin
            active[id]     = 0;
            p_sync[id]     = 1'b1;
            p_sclk[id]     = 1'b1;
            p_data[id]     = 1'b0;
            since_chg[id]  = 1000;
            since_fall[id] = 1000;
            high_cnt[id]   = 0;
            gap_len[id]    = 0;
            stab_bad[id]   = 0;
            sclk_bad[id]   = 0;
            busy_bad[id]   = 0;
            return;
        end
        if (since_chg[id] < 1000) since_chg[id]++;
        if (since_fall[id] < 1000) since_fall[id]++;
        if (active[id]) t_c[id]++;

        if (s && p_sync[id] && (k != p_sclk[id])) sclk_bad[id] = 1;

        if (!s && p_sync[id]) begin
            checkOutput($sformatf("dut%0d_done_before_next_frame", id), active[id], 0);
            checkOutput($sformatf("dut%0d_sclk_idle_toggle", id), sclk_bad[id], 0);
            active[id]   = 1;
            t_c[id]      = 0;
            falls[id]    = 0;
            word[id]     = '0;
            busy_bad[id] = 0;
            stab_bad[id] = 0;
            sclk_bad[id] = 0;
            gap_len[id]  = high_cnt[id];
        end else if (s) begin
            high_cnt[id] = p_sync[id] ? high_cnt[id] + 1 : 1;
        end

        fell = !s && p_sclk[id] && !k;
        chg  = (d != p_data[id]);
        if (fell && (chg || since_chg[id] < cdiv)) stab_bad[id] = 1;
        if (chg && (fell || since_fall[id] < cdiv)) stab_bad[id] = 1;
        if (fell) begin
            word[id] = {word[id][14:0], d};
            falls[id]++;
            since_fall[id] = 0;
        end
        if (chg) since_chg[id] = 0;

        if (s && !p_sync[id] && active[id]) begin
            checkOutput($sformatf("dut%0d_fall_count", id), falls[id], 16);
            checkOutput($sformatf("dut%0d_sync_low_len", id), t_c[id], 32 * cdiv);
            checkOutput($sformatf("dut%0d_data_stable", id), stab_bad[id], 0);
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                checkOutput($sformatf("dut%0d_unexpected_frame", id), word[id], 32'hFFFF_FFFF);
            end else begin
                exp = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                checkOutput($sformatf("dut%0d_frame_word", id), word[id], exp);
            end
        end

        if (dn) begin
            checkOutput($sformatf("dut%0d_done_in_frame", id), active[id], 1);
            if (active[id]) begin
                checkOutput($sformatf("dut%0d_done_time", id), t_c[id], 33 * cdiv);
                checkOutput($sformatf("dut%0d_busy_during_frame", id), busy_bad[id], 0);
                checkOutput($sformatf("dut%0d_busy_at_done", id), b, 0);
            end
            active[id] = 0;
        end else if (active[id]) begin
            if (!b) busy_bad[id] = 1;
            if (t_c[id] > 33 * cdiv + 4) begin
                checkOutput($sformatf("dut%0d_frame_timeout", id), t_c[id], 33 * cdiv);
                active[id] = 0;
            end
        end

        p_sync[id] = s;
        p_sclk[id] = k;
        p_data[id] = d;
    endtask

    always @(negedge clock_In) begin
        monitorStep(0, C0, Reset, sync0, sclk0, dac0, busy0, done0);
        monitorStep(1, C1, Reset, sync1, sclk1, dac1, busy1, done1);
    end

    // One start pulse; the expected frame is queued only when the frame should complete
    task automatic applyStimulus(input int id, input logic [11:0] val,
                                 input logic [15:0] exp, input bit push);
        @(posedge clock_In);
        #1;
        if (id == 0) begin
            data0 = val; start0 = 1'b1;
            if (push) exp_q0.push_back(exp);
        end else begin
            data1 = val; start1 = 1'b1;
            if (push) exp_q1.push_back(exp);
        end
        @(posedge clock_In);
        #1;
        if (id == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic waitDone(input int id);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock_In);
            seen = (id == 0) ? done0 : done1;
        end
        checkOutput($sformatf("dut%0d_done_seen", id), seen, 1);
    endtask

    task automatic checkIdle(input int id, input string tag);
        checkOutput($sformatf("dut%0d_%s_sync", id, tag), (id == 0) ? sync0 : sync1, 1);
        checkOutput($sformatf("dut%0d_%s_sclk", id, tag), (id == 0) ? sclk0 : sclk1, 1);
        checkOutput($sformatf("dut%0d_%s_data", id, tag), (id == 0) ? dac0 : dac1, 0);
        checkOutput($sformatf("dut%0d_%s_busy", id, tag), (id == 0) ? busy0 : busy1, 0);
        checkOutput($sformatf("dut%0d_%s_done", id, tag), (id == 0) ? done0 : done1, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset  = 1'b1;
        data0  = '0;
        data1  = '0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge clock_In);
        #1;
        checkIdle(0, "reset");
        checkIdle(1, "reset");
        Reset = 1'b0;
        repeat (2) @(posedge clock_In);

        $display("[TB] single frame 0xA5C");
        applyStimulus(0, 12'hA5C, 16'h0A5C, 1);
        waitDone(0);

        $display("[TB] back-to-back 0xFFF then 0x000");
        @(posedge clock_In);
        #1;
        data0 = 12'hFFF; start0 = 1'b1;
        exp_q0.push_back(16'h0FFF);
        @(posedge clock_In);
        #1;
        data0 = 12'h000;
        exp_q0.push_back(16'h0000);
        waitDone(0);
        @(posedge clock_In);
        #1;
        start0 = 1'b0;
        waitDone(0);
        checkOutput("dut0_backtoback_gap", gap_len[0], C0 + 1);

        $display("[TB] start re-pulsed mid-frame is ignored");
        applyStimulus(0, 12'h3C6, 16'h03C6, 1);
        repeat (39) @(posedge clock_In);
        #1;
        data0 = 12'h123; start0 = 1'b1;
        @(posedge clock_In);
        #1;
        start0 = 1'b0;
        waitDone(0);
        repeat (20) @(posedge clock_In);
        checkOutput("dut0_no_extra_frame_sync", sync0, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 12'hFFF, 16'h0000, 0);
        repeat (50) @(posedge clock_In);
        checkOutput("dut0_pre_abort_sync_low", sync0, 0);
        #2;
        Reset = 1'b1;
        #1;
        checkIdle(0, "abort");
        repeat (2) @(posedge clock_In);
        #1;
        Reset = 1'b0;
        repeat (3) @(posedge clock_In);
        applyStimulus(0, 12'h9E1, 16'h09E1, 1);
        waitDone(0);

        $display("[TB] CLK_DIV=2 with power-down bits 11");
        applyStimulus(1, 12'h800, 16'h3800, 1);
        waitDone(1);
        applyStimulus(1, 12'h001, 16'h3001, 1);
        waitDone(1);

        repeat (10) @(posedge clock_In);
        checkOutput("dut0_queue_drained", exp_q0.size(), 0);
        checkOutput("dut1_queue_drained", exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
